// File: rtl/bt_uart_pkg.sv
// Shared types and constants for the Bluetooth UART receive path.
package bt_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int OVERSAMPLE = 8;
   localparam int DATA_BITS  = 8;
   localparam int PH_MID     = 4;

endpackage

// File: rtl/bluetooth_rx_if.sv
// Tick/line inputs and deframed byte outputs of the Bluetooth UART receiver.
interface bluetooth_rx_if;

   logic       sample_tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;

   modport master (
      output sample_tick, rx,
      input  rx_data, data_valid, parity_err, frame_err
   );

   modport slave (
      input  sample_tick, rx,
      output rx_data, data_valid, parity_err, frame_err
   );

endinterface

// File: rtl/bt_rx_sync.sv
// rx line synchronizer (flops reset to the idle-high level) and tick-qualified
// falling-edge detector.
module bt_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_in,
   input  logic sample_tick,
   input  logic rx,
   output logic rx_s,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_prev;

   // Shift the asynchronous line through the synchronizer chain every clk.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
      if (rst_in) sync_q <= '1;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   // Remember the synchronized line value at the previous sample tick.
   always_ff @(posedge clk) begin
      if (rst_in)           rx_prev <= 1'b1;
      else if (sample_tick) rx_prev <= rx_s;
   end

   assign fall = sample_tick & rx_prev & ~rx_s;

endmodule

// File: rtl/bluetooth_rx.sv
// 8E1 UART receiver, 8x oversampled. Define BT_RX_MAJORITY_EN to take each bit
// as the 2-of-3 vote of samples at phases 3,4,5 (decision at phase 5); the
// default build takes a single sample at phase 4.
module bluetooth_rx
   import bt_uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst_in,
   bluetooth_rx_if.slave  bus
);

   localparam int PH_W = $clog2(OVERSAMPLE);

   rx_state_t             state, next_state;
   logic                  rx_s, fall;
   logic [PH_W-1:0]       ph;
   logic [2:0]            bit_cnt;
   logic [DATA_BITS-1:0]  shift;
   logic                  par_bit;
   logic                  bit_val;
   logic                  is_dp;

   bt_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk         (clk),
      .rst_in      (rst_in),
      .sample_tick (bus.sample_tick),
      .rx          (bus.rx),
      .rx_s        (rx_s),
      .fall        (fall)
   );

`ifdef BT_RX_MAJORITY_EN
   localparam logic [PH_W-1:0] DP_PH = PH_W'(PH_MID + 1);
   logic [1:0] votes;

   // Keep the two most recent tick samples for the 2-of-3 vote.
   always_ff @(posedge clk) begin
      if (rst_in)               votes <= 2'b11;
      else if (bus.sample_tick) votes <= {votes[0], rx_s};
   end

   assign bit_val = (votes[1] & votes[0]) | (votes[1] & rx_s) | (votes[0] & rx_s);
`else
   localparam logic [PH_W-1:0] DP_PH = PH_W'(PH_MID);

   assign bit_val = rx_s;
`endif

   assign is_dp = bus.sample_tick && (ph == DP_PH);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst_in) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic: one decision per bit, taken at the decision-point tick.
   always_comb begin
      // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
      next_state = state;
      case (state)
         IDLE:    if (fall)  next_state = START;
         START:   if (is_dp) next_state = bit_val ? IDLE : DATA;
         DATA:    if (is_dp && bit_cnt == 3'(DATA_BITS - 1)) next_state = PARITY;
         PARITY:  if (is_dp) next_state = STOP;
         STOP:    if (is_dp) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Phase counter, bit counter, shift register and registered frame outputs.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         ph             <= '0;
         bit_cnt        <= '0;
         shift          <= '0;
         par_bit        <= 1'b0;
         bus.rx_data    <= 8'h00;
         bus.data_valid <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.frame_err  <= 1'b0;
      end else begin
         bus.data_valid <= 1'b0;
         if (bus.sample_tick)
            ph <= (state == IDLE && fall) ? '0 : ph + 1'b1;
         if (is_dp) begin
            case (state)
               START:  if (!bit_val) bit_cnt <= '0;
               DATA: begin
                  shift   <= {bit_val, shift[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY: par_bit <= bit_val;
               STOP: begin
                  bus.rx_data    <= shift;
                  bus.parity_err <= par_bit ^ (^shift);
                  bus.frame_err  <= ~bit_val;
                  bus.data_valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bluetooth_rx.sv
// Self-checking bench for bluetooth_rx: directed 8E1 scenarios plus random
// frames, compared against a frame-level reference model.
module tb_bluetooth_rx;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } frame_t;

   logic clk = 1'b0;
   logic rst_in = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   tick_div = 0;
   int   wide_cnt = 0;
   logic dv_prev = 1'b0;
   frame_t got_q[$];

   bluetooth_rx_if bus ();

   bluetooth_rx #(.SYNC_STAGES(2)) dut (
      .clk    (clk),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // One sample tick every 4 clk, so a one-clk data_valid is distinguishable from one tick.
   always @(negedge clk) begin
      bus.sample_tick = (tick_div == 0);
      tick_div = (tick_div + 1) % 4;
   end

   // Collect every completed frame and flag any data_valid longer than one clk.
   always @(negedge clk) begin
      if (!rst_in && bus.data_valid)
         got_q.push_back('{bus.rx_data, bus.parity_err, bus.frame_err});
      if (bus.data_valid && dv_prev) wide_cnt++;
      dv_prev = bus.data_valid;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Reference: even parity over data+parity bit, framing error when stop is low.
   function automatic frame_t model(input logic [7:0] d, input logic p, input logic s);
      frame_t m;
      m.data = d;
      m.perr = ((($countones(d) + int'(p)) % 2) == 1);
      m.ferr = !s;
      return m;
   endfunction

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!bus.sample_tick) @(posedge clk);
      end
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.rx = b;
      wait_ticks(8);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(p);
      send_bit(s);
      bus.rx = 1'b1;
   endtask

   task automatic get_frame(output frame_t f, output bit ok);
      int n = 0;
      while (got_q.size() == 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      #1;
      ok = (got_q.size() > 0);
      f  = ok ? got_q.pop_front() : '0;
   endtask

   task automatic test_reset();
      bus.rx = 1'b1;
      rst_in = 1'b1;
      repeat (6) @(posedge clk);
      #1 rst_in = 1'b0;
      wait_ticks(4);
      total++;
      if ({bus.rx_data, bus.data_valid, bus.parity_err, bus.frame_err} !== 11'b0) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=000",
                  {bus.rx_data, bus.data_valid, bus.parity_err, bus.frame_err});
      end
      total++;
      if (got_q.size() != 0) begin
         bad++;
         $display("FAIL reset_no_frame got=%0d exp=0", got_q.size());
      end
   endtask

   task automatic test_basic();
      frame_t f;
      bit ok;
      send_frame(8'hA5, 1'b0, 1'b1);
      get_frame(f, ok);
      total++;
      if (!ok || f !== model(8'hA5, 1'b0, 1'b1)) begin
         bad++;
         $display("FAIL basic_a5 got=%h ok=%0d exp=%h", f, ok, model(8'hA5, 1'b0, 1'b1));
      end
      wait_ticks(20);
      total++;
      if (got_q.size() != 0 || bus.rx_data !== 8'hA5) begin
         bad++;
         $display("FAIL basic_hold got=%h extra=%0d exp=a5", bus.rx_data, got_q.size());
      end
   endtask

   task automatic test_parity();
      frame_t f;
      bit ok;
      send_frame(8'h01, 1'b1, 1'b1);
      get_frame(f, ok);
      total++;
      if (!ok || f !== model(8'h01, 1'b1, 1'b1)) begin
         bad++;
         $display("FAIL parity_ok got=%h ok=%0d exp=%h", f, ok, model(8'h01, 1'b1, 1'b1));
      end
      wait_ticks(4);
      send_frame(8'h01, 1'b0, 1'b1);
      get_frame(f, ok);
      total++;
      if (!ok || f !== model(8'h01, 1'b0, 1'b1)) begin
         bad++;
         $display("FAIL parity_err got=%h ok=%0d exp=%h", f, ok, model(8'h01, 1'b0, 1'b1));
      end
      wait_ticks(10);
      total++;
      if (bus.parity_err !== 1'b1) begin
         bad++;
         $display("FAIL parity_held got=%b exp=1", bus.parity_err);
      end
   endtask

   task automatic test_break();
      frame_t f;
      bit ok;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(bit'(8'h3C >> i));
      send_bit(1'b0);
      send_bit(1'b0);
      wait_ticks(40);
      get_frame(f, ok);
      total++;
      if (!ok || f !== model(8'h3C, 1'b0, 1'b0)) begin
         bad++;
         $display("FAIL break_frame got=%h ok=%0d exp=%h", f, ok, model(8'h3C, 1'b0, 1'b0));
      end
      total++;
      if (got_q.size() != 0 || bus.frame_err !== 1'b1) begin
         bad++;
         $display("FAIL break_held frames=%0d ferr=%b exp=0,1", got_q.size(), bus.frame_err);
      end
      bus.rx = 1'b1;
      wait_ticks(16);
      total++;
      if (got_q.size() != 0) begin
         bad++;
         $display("FAIL break_release frames=%0d exp=0", got_q.size());
      end
      send_frame(8'h12, 1'b0, 1'b1);
      get_frame(f, ok);
      total++;
      if (!ok || f !== model(8'h12, 1'b0, 1'b1)) begin
         bad++;
         $display("FAIL break_recover got=%h ok=%0d exp=%h", f, ok, model(8'h12, 1'b0, 1'b1));
      end
   endtask

   task automatic test_glitch();
      frame_t f;
      bit ok;
      wait_ticks(8);
      bus.rx = 1'b0;
      wait_ticks(2);
      bus.rx = 1'b1;
      wait_ticks(24);
`ifdef BT_RX_MAJORITY_EN
      bus.rx = 1'b0;
      wait_ticks(1);
      bus.rx = 1'b1;
      wait_ticks(24);
`endif
      total++;
      if (got_q.size() != 0) begin
         bad++;
         $display("FAIL glitch_rejected frames=%0d exp=0", got_q.size());
      end
      send_frame(8'hC3, 1'b0, 1'b1);
      get_frame(f, ok);
      total++;
      if (!ok || f !== model(8'hC3, 1'b0, 1'b1)) begin
         bad++;
         $display("FAIL glitch_recover got=%h ok=%0d exp=%h", f, ok, model(8'hC3, 1'b0, 1'b1));
      end
   endtask

   task automatic test_back_to_back();
      frame_t f;
      bit ok;
      send_frame(8'h55, 1'b0, 1'b1);
      send_frame(8'hAA, 1'b0, 1'b1);
      get_frame(f, ok);
      total++;
      if (!ok || f !== model(8'h55, 1'b0, 1'b1)) begin
         bad++;
         $display("FAIL b2b_first got=%h ok=%0d exp=%h", f, ok, model(8'h55, 1'b0, 1'b1));
      end
      get_frame(f, ok);
      total++;
      if (!ok || f !== model(8'hAA, 1'b0, 1'b1)) begin
         bad++;
         $display("FAIL b2b_second got=%h ok=%0d exp=%h", f, ok, model(8'hAA, 1'b0, 1'b1));
      end
   endtask

   task automatic test_reset_mid();
      frame_t f;
      bit ok;
      send_frame(8'h81, 1'b1, 1'b1);
      get_frame(f, ok);
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(bit'(8'h7E >> i));
      bus.rx = 1'b1;
      wait_ticks(3);
      rst_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({bus.rx_data, bus.data_valid, bus.parity_err, bus.frame_err} !== 11'b0) begin
         bad++;
         $display("FAIL reset_mid_outputs got=%h exp=000",
                  {bus.rx_data, bus.data_valid, bus.parity_err, bus.frame_err});
      end
      rst_in = 1'b0;
      wait_ticks(100);
      total++;
      if (got_q.size() != 0) begin
         bad++;
         $display("FAIL reset_mid_no_frame frames=%0d exp=0", got_q.size());
      end
      send_frame(8'h7E, 1'b0, 1'b1);
      get_frame(f, ok);
      total++;
      if (!ok || f !== model(8'h7E, 1'b0, 1'b1)) begin
         bad++;
         $display("FAIL reset_mid_next got=%h ok=%0d exp=%h", f, ok, model(8'h7E, 1'b0, 1'b1));
      end
   endtask

   task automatic test_random();
      frame_t f;
      bit ok;
      logic [7:0] d;
      logic p, s;
      for (int n = 0; n < 24; n++) begin
         d = 8'($urandom);
         p = 1'($urandom);
         s = ($urandom_range(0, 4) != 0);
         send_frame(d, p, s);
         wait_ticks($urandom_range(2, 8));
         get_frame(f, ok);
         total++;
         if (!ok || f !== model(d, p, s)) begin
            bad++;
            $display("FAIL random_%0d got=%h ok=%0d exp=%h", n, f, ok, model(d, p, s));
         end
      end
   endtask

   task automatic test_pulse_width();
      total++;
      if (wide_cnt != 0) begin
         bad++;
         $display("FAIL valid_pulse_width wide=%0d exp=0", wide_cnt);
      end
   endtask

   initial begin
      bus.rx = 1'b1;
      test_reset();
      test_basic();
      test_parity();
      test_break();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_pulse_width();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
